// File: rtl/signature_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : signature_analyzer
// Purpose  : 16-bit multiple-input signature register (MISR) that compacts a
//            stream of 8-bit samples from a circuit-under-test. A run is
//            started with 'start', accepts NUM_SAMPLES qualified samples and
//            then parks in DONE with the final signature on 'signature'.
//            Polynomial x^16 + x^12 + x^5 + 1 (16'h1021).
// Options  : define SIG_PARITY_EN to add the registered 'sig_parity' output
//            (XOR of all signature bits).
// Revision : 1.0 - initial release
// ============================================================================
module signature_analyzer #(
    parameter int unsigned NUM_SAMPLES = 256,
    parameter logic [15:0] SEED        = 16'h0000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
`ifdef SIG_PARITY_EN
    output logic        sig_parity,
`endif
    output logic [15:0] sample_count
);

    // State encoding; busy/done are held in their own flops alongside it.
    localparam logic [1:0]  c_idle = 2'd0;
    localparam logic [1:0]  c_run  = 2'd1;
    localparam logic [1:0]  c_done = 2'd2;
    localparam logic [15:0] c_poly = 16'h1021;
    // NUM_SAMPLES is limited to 1..65535, so it always fits the 16-bit counter.
    localparam logic [15:0] c_num  = 16'(NUM_SAMPLES);

    logic [1:0]  r_state;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_sig;
    logic [15:0] r_cnt;

    logic [15:0] w_sig_next;
    logic [15:0] w_cnt_next;
    logic        w_accept;
    logic        w_last;

    // Next signature/count for an accepted sample and end-of-run detection.
    always_comb begin
        w_sig_next = {r_sig[14:0], 1'b0}
                   ^ (r_sig[15] ? c_poly : 16'h0000)
                   ^ {8'h00, data_in};
        w_cnt_next = r_cnt + 16'd1;
        w_accept   = (r_state == c_run) && in_valid;
        w_last     = w_accept && (w_cnt_next == c_num);
    end

    // Control FSM plus signature and sample counter; clear overrides everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sig   <= SEED;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    // Data on the start cycle is deliberately not captured.
                    if (start) begin
                        r_state <= c_run;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_sig   <= SEED;
                        r_cnt   <= 16'd0;
                    end
                end
                c_run: begin
                    // start is ignored here; only in_valid advances the run.
                    if (w_accept) begin
                        r_sig <= w_sig_next;
                        r_cnt <= w_cnt_next;
                        if (w_last) begin
                            r_state <= c_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIG_PARITY_EN
    logic r_par;

    // Parity flop tracks every signature load so it stays aligned with it.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_par <= ^SEED;
        end else if (((r_state == c_idle) || (r_state == c_done)) && start) begin
            r_par <= ^SEED;
        end else if (w_accept) begin
            r_par <= ^w_sig_next;
        end
    end

    assign sig_parity = r_par;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign signature    = r_sig;
    assign sample_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_signature_analyzer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_signature_analyzer
// Purpose  : Self-checking bench for signature_analyzer. Four instances share
//            one stimulus stream: A (N=4, SEED=0), B (N=10, SEED=0),
//            C (N=1, SEED=0) and P (N=10, SEED=1). Build with SIG_PARITY_EN
//            defined to also check sig_parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signature_analyzer;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear    = 1'b0;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] data_in  = 8'h00;

    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c, busy_p, done_p;
    logic [15:0] sig_a, cnt_a, sig_b, cnt_b, sig_c, cnt_c, sig_p, cnt_p;
`ifdef SIG_PARITY_EN
    logic        par_a, par_b, par_c, par_p;
`endif

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_p[$];

    signature_analyzer #(.NUM_SAMPLES(4), .SEED(16'h0000)) u_dut_a (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
        .data_in(data_in), .busy(busy_a), .done(done_a), .signature(sig_a),
`ifdef SIG_PARITY_EN
        .sig_parity(par_a),
`endif
        .sample_count(cnt_a)
    );

    signature_analyzer #(.NUM_SAMPLES(10), .SEED(16'h0000)) u_dut_b (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
        .data_in(data_in), .busy(busy_b), .done(done_b), .signature(sig_b),
`ifdef SIG_PARITY_EN
        .sig_parity(par_b),
`endif
        .sample_count(cnt_b)
    );

    signature_analyzer #(.NUM_SAMPLES(1), .SEED(16'h0000)) u_dut_c (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
        .data_in(data_in), .busy(busy_c), .done(done_c), .signature(sig_c),
`ifdef SIG_PARITY_EN
        .sig_parity(par_c),
`endif
        .sample_count(cnt_c)
    );

    signature_analyzer #(.NUM_SAMPLES(10), .SEED(16'h0001)) u_dut_p (
        .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
        .data_in(data_in), .busy(busy_p), .done(done_p), .signature(sig_p),
`ifdef SIG_PARITY_EN
        .sig_parity(par_p),
`endif
        .sample_count(cnt_p)
    );

    // Reference compaction step (CRC-CCITT style shift with 8-bit injection).
    function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] fb;
        fb = s[15] ? 16'h1021 : 16'h0000;
        return {s[14:0], 1'b0} ^ fb ^ {8'h00, d};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] d);
        start    = 1'b1;
        in_valid = v;
        data_in  = d;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        // clear wins over start and in_valid on the same edge
        clear = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 8'hAA;
        tick();
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (sig_a !== 16'h0000) begin n_err++; $display("FAIL reset_sig: got %h want 0000", sig_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if (sig_p !== 16'h0001) begin n_err++; $display("FAIL reset_seed: got %h want 0001", sig_p); end
`ifdef SIG_PARITY_EN
        n_cmp++; if (par_p !== 1'b1) begin n_err++; $display("FAIL reset_par_p: got %b want 1", par_p); end
        n_cmp++; if (par_a !== 1'b0) begin n_err++; $display("FAIL reset_par_a: got %b want 0", par_a); end
`endif
        // IDLE ignores in_valid
        in_valid = 1'b1; data_in = 8'h5A;
        tick(); tick();
        in_valid = 1'b0;
        n_cmp++; if (sig_a !== 16'h0000 || cnt_a !== 16'd0 || busy_a !== 1'b0)
            begin n_err++; $display("FAIL idle_ignore: got sig=%h cnt=%0d busy=%b want 0000/0/0", sig_a, cnt_a, busy_a); end
    endtask

    task automatic test_basic();
        logic [7:0]  d [4];
        logic [15:0] s;
        d = '{8'h01, 8'h00, 8'h00, 8'h00};
        s = 16'h0000;
        for (int i = 0; i < 4; i++) s = misr(s, d[i]);
        sb_a.push_back('{sig: s, cnt: 16'd4});
        pulse_start(1'b0, 8'h00);
        n_cmp++; if (busy_a !== 1'b1 || done_a !== 1'b0)
            begin n_err++; $display("FAIL basic_start: got busy=%b done=%b want 1/0", busy_a, done_a); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; data_in = d[i];
            tick();
            if (i == 0) begin
                n_cmp++; if (done_c !== 1'b1 || sig_c !== 16'h0001 || cnt_c !== 16'd1)
                    begin n_err++; $display("FAIL n1_done: got done=%b sig=%h cnt=%0d want 1/0001/1", done_c, sig_c, cnt_c); end
            end
            if (i == 2) begin
                n_cmp++; if (done_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 16'd3)
                    begin n_err++; $display("FAIL basic_early: got done=%b busy=%b cnt=%0d want 0/1/3", done_a, busy_a, cnt_a); end
            end
        end
        in_valid = 1'b0;
        begin
            exp_t e;
            e = sb_a.pop_front();
            n_cmp++; if (sig_a !== e.sig || sig_a !== 16'h0008)
                begin n_err++; $display("FAIL basic_sig: got %h want %h", sig_a, e.sig); end
            n_cmp++; if (cnt_a !== e.cnt) begin n_err++; $display("FAIL basic_cnt: got %0d want %0d", cnt_a, e.cnt); end
            n_cmp++; if (done_a !== 1'b1 || busy_a !== 1'b0)
                begin n_err++; $display("FAIL basic_done: got done=%b busy=%b want 1/0", done_a, busy_a); end
        end
        n_cmp++; if (sig_c !== 16'h0001 || cnt_c !== 16'd1)
            begin n_err++; $display("FAIL n1_hold: got sig=%h cnt=%0d want 0001/1", sig_c, cnt_c); end
    endtask

    task automatic test_done_hold();
        in_valid = 1'b1; data_in = 8'h55;
        tick(); tick(); tick();
        in_valid = 1'b0;
        n_cmp++; if (sig_a !== 16'h0008 || cnt_a !== 16'd4 || done_a !== 1'b1)
            begin n_err++; $display("FAIL done_hold: got sig=%h cnt=%0d done=%b want 0008/4/1", sig_a, cnt_a, done_a); end
    endtask

    task automatic test_gaps();
        logic        v [7];
        logic [7:0]  d [7];
        logic [15:0] s;
        logic        gap_ok;
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        d = '{8'h01, 8'h77, 8'h77, 8'h00, 8'h33, 8'h00, 8'h00};
        s = 16'h0000;
        for (int i = 0; i < 7; i++) if (v[i]) s = misr(s, d[i]);
        sb_a.push_back('{sig: s, cnt: 16'd4});
        pulse_start(1'b0, 8'h00);
        gap_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = v[i]; data_in = d[i];
            tick();
            if (!v[i] && busy_a !== 1'b1) gap_ok = 1'b0;
        end
        in_valid = 1'b0;
        n_cmp++; if (gap_ok !== 1'b1) begin n_err++; $display("FAIL gaps_busy: got busy dropped in gap, want busy held"); end
        begin
            exp_t e;
            e = sb_a.pop_front();
            n_cmp++; if (sig_a !== e.sig || sig_a !== 16'h0008)
                begin n_err++; $display("FAIL gaps_sig: got %h want %h", sig_a, e.sig); end
            n_cmp++; if (cnt_a !== e.cnt || done_a !== 1'b1)
                begin n_err++; $display("FAIL gaps_done: got cnt=%0d done=%b want %0d/1", cnt_a, done_a, e.cnt); end
        end
    endtask

    task automatic test_start_in_run();
        logic [7:0]  d [4];
        logic [15:0] s;
        d = '{8'h01, 8'h00, 8'h00, 8'h00};
        s = 16'h0000;
        for (int i = 0; i < 4; i++) s = misr(s, d[i]);
        sb_a.push_back('{sig: s, cnt: 16'd4});
        // restart from DONE with data on the start cycle (must not be captured)
        pulse_start(1'b1, 8'hFF);
        n_cmp++; if (busy_a !== 1'b1 || done_a !== 1'b0 || sig_a !== 16'h0000 || cnt_a !== 16'd0)
            begin n_err++; $display("FAIL restart: got busy=%b done=%b sig=%h cnt=%0d want 1/0/0000/0", busy_a, done_a, sig_a, cnt_a); end
        for (int i = 0; i < 4; i++) begin
            start    = (i == 1);
            in_valid = 1'b1; data_in = d[i];
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        begin
            exp_t e;
            e = sb_a.pop_front();
            n_cmp++; if (sig_a !== e.sig) begin n_err++; $display("FAIL runstart_sig: got %h want %h", sig_a, e.sig); end
            n_cmp++; if (cnt_a !== e.cnt || done_a !== 1'b1)
                begin n_err++; $display("FAIL runstart_done: got cnt=%0d done=%b want %0d/1", cnt_a, done_a, e.cnt); end
        end
    endtask

    task automatic test_long();
        logic [7:0]  d [10];
        logic [15:0] sb, sp;
        int          waited;
        for (int i = 0; i < 10; i++) d[i] = (i == 0) ? 8'h80 : 8'h00;
        sb = 16'h0000;
        sp = 16'h0001;
        for (int i = 0; i < 10; i++) begin sb = misr(sb, d[i]); sp = misr(sp, d[i]); end
        sb_b.push_back('{sig: sb, cnt: 16'd10});
        sb_p.push_back('{sig: sp, cnt: 16'd10});
        do_clear();
        pulse_start(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; data_in = d[i];
            tick();
        end
        in_valid = 1'b0;
        waited = 0;
        while (done_b !== 1'b1 && waited < 8) begin tick(); waited++; end
        if (done_b !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL long_timeout: got done=%b want 1 within 8 cycles", done_b);
        end
        n_cmp++; if (waited != 0) begin n_err++; $display("FAIL long_latency: got %0d extra cycles want 0", waited); end
        begin
            exp_t e;
            e = sb_b.pop_front();
            n_cmp++; if (sig_b !== e.sig || sig_b !== 16'h1021)
                begin n_err++; $display("FAIL long_sig: got %h want %h", sig_b, e.sig); end
            n_cmp++; if (cnt_b !== e.cnt) begin n_err++; $display("FAIL long_cnt: got %0d want %0d", cnt_b, e.cnt); end
`ifdef SIG_PARITY_EN
            n_cmp++; if (par_b !== ^e.sig) begin n_err++; $display("FAIL long_par_b: got %b want %b", par_b, ^e.sig); end
`endif
            e = sb_p.pop_front();
            n_cmp++; if (sig_p !== e.sig || done_p !== 1'b1)
                begin n_err++; $display("FAIL seed1_sig: got %h done=%b want %h/1", sig_p, done_p, e.sig); end
`ifdef SIG_PARITY_EN
            n_cmp++; if (par_p !== ^e.sig) begin n_err++; $display("FAIL seed1_par: got %b want %b", par_p, ^e.sig); end
`endif
        end
    endtask

    task automatic test_clear_mid();
        logic saw_done;
        pulse_start(1'b0, 8'h00);
        in_valid = 1'b1; data_in = 8'h12; tick();
        data_in = 8'h34; tick();
        n_cmp++; if (cnt_a !== 16'd2 || busy_a !== 1'b1)
            begin n_err++; $display("FAIL mid_pre: got cnt=%0d busy=%b want 2/1", cnt_a, busy_a); end
        clear = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 8'h56;
        tick();
        clear = 1'b0; start = 1'b0;
        n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 16'h0000 || cnt_a !== 16'd0)
            begin n_err++; $display("FAIL mid_clear: got busy=%b done=%b sig=%h cnt=%0d want 0/0/0000/0", busy_a, done_a, sig_a, cnt_a); end
        saw_done = 1'b0;
        data_in = 8'h11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw_done = 1'b1;
        end
        in_valid = 1'b0;
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL mid_nodone: got activity after clear want idle"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_done_hold();
        test_gaps();
        test_start_in_run();
        test_long();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
